user_bitstream_feeder: RTL and testbench



---
 rtl/user_bitstream_feeder_pkg.sv | 59 +++++
 rtl/user_bitstream_feeder_regs.sv | 120 ++++++++++++
 rtl/user_bitstream_feeder.sv | 168 ++++++++++++++++
 tb/tb_user_bitstream_feeder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_bitstream_feeder_pkg.sv
// rtl/user_bitstream_feeder_pkg.sv - shared OBI types, register map and FSM states for the feeder
package user_bitstream_feeder_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
        logic        rready;
    } obi_req_s;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_s;

    // Register offsets as seen on addr[3:2]
    localparam logic [1:0] RegSrc  = 2'd0;
    localparam logic [1:0] RegLen  = 2'd1;
    localparam logic [1:0] RegDst  = 2'd2;
    localparam logic [1:0] RegCtrl = 2'd3;

    // CTRL (write) and STATUS (read) bit positions
    localparam int unsigned CtrlStartBit = 0;
    localparam int unsigned StatBusyBit  = 0;
    localparam int unsigned StatDoneBit  = 1;
    localparam int unsigned StatErrBit   = 2;
    localparam int unsigned StatCntLsb   = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRdReq  = 3'd1,
        StRdWait = 3'd2,
        StWrReq  = 3'd3,
        StWrWait = 3'd4
    } feeder_state_e;

endpackage

// File: rtl/user_bitstream_feeder_regs.sv
// rtl/user_bitstream_feeder_regs.sv - OBI subordinate register file for the bitstream feeder
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   sbr_obi_req_i/_rsp_o     configuration OBI subordinate port (gnt = req, rvalid one cycle later)
//   busy_i, done_i, err_i    transfer status from the FSM
//   cnt_i                    words transferred so far
//   src_o, len_o, dst_o      programmed transfer parameters
//   start_o                  single-cycle start request, only raised while idle
module user_bitstream_feeder_regs
    import user_bitstream_feeder_pkg::*;
#(
    parameter obi_cfg_t ObiCfg    = ObiDefaultConfig,
    parameter type      obi_req_t = obi_req_s,
    parameter type      obi_rsp_t = obi_rsp_s
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  obi_req_t                    sbr_obi_req_i,
    output obi_rsp_t                    sbr_obi_rsp_o,
    input  logic                        busy_i,
    input  logic                        done_i,
    input  logic                        err_i,
    input  logic [15:0]                 cnt_i,
    output logic [ObiCfg.AddrWidth-1:0] src_o,
    output logic [15:0]                 len_o,
    output logic [ObiCfg.AddrWidth-1:0] dst_o,
    output logic                        start_o
);

    logic [ObiCfg.AddrWidth-1:0] src_q;
    logic [ObiCfg.AddrWidth-1:0] dst_q;
    logic [15:0]                 len_q;
    logic                        rvalid_q;
    logic [0:0]                  rid_q;
    logic [31:0]                 rdata_q;
    logic                        rerr_q;

    logic [1:0]  reg_sel;
    logic        wr_req;
    logic        wr_blocked;
    logic [31:0] status;
    logic [31:0] rdata_d;

    assign reg_sel = sbr_obi_req_i.a.addr[3:2];
    assign wr_req  = sbr_obi_req_i.req & sbr_obi_req_i.a.we;
    assign status  = {cnt_i, 13'd0, err_i, done_i, busy_i};

    // While busy every parameter write is refused; a CTRL write is only
    // refused when it actually asks for START.
    always_comb begin
        wr_blocked = 1'b0;
        if (busy_i) begin
            if (reg_sel == RegCtrl) begin
                wr_blocked = sbr_obi_req_i.a.wdata[CtrlStartBit];
            end else begin
                wr_blocked = 1'b1;
            end
        end
    end

    assign start_o = wr_req & (reg_sel == RegCtrl)
                   & sbr_obi_req_i.a.wdata[CtrlStartBit] & ~busy_i;

    always_comb begin
        rdata_d = 32'd0;
        case (reg_sel)
            RegSrc:  rdata_d = src_q;
            RegLen:  rdata_d = {16'd0, len_q};
            RegDst:  rdata_d = dst_q;
            default: rdata_d = status;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            rvalid_q <= sbr_obi_req_i.req;
            if (sbr_obi_req_i.req) begin
                rid_q   <= sbr_obi_req_i.a.aid;
                rdata_q <= sbr_obi_req_i.a.we ? 32'd0 : rdata_d;
                rerr_q  <= wr_req & wr_blocked;
            end
            // Byte enables are ignored: registers are always written as whole words
            if (wr_req && !wr_blocked) begin
                case (reg_sel)
                    RegSrc:  src_q <= {sbr_obi_req_i.a.wdata[31:2], 2'b00};
                    RegLen:  len_q <= sbr_obi_req_i.a.wdata[15:0];
                    RegDst:  dst_q <= {sbr_obi_req_i.a.wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        sbr_obi_rsp_o          = '0;
        sbr_obi_rsp_o.gnt      = sbr_obi_req_i.req;
        sbr_obi_rsp_o.rvalid   = rvalid_q;
        sbr_obi_rsp_o.r.rdata  = rdata_q;
        sbr_obi_rsp_o.r.rid    = rid_q;
        sbr_obi_rsp_o.r.err    = rerr_q;
    end

    assign src_o = src_q;
    assign len_o = len_q;
    assign dst_o = dst_q;

    logic unused_sbr;
    assign unused_sbr = ^{sbr_obi_req_i.rready, sbr_obi_req_i.a.be,
                          sbr_obi_req_i.a.addr[31:4], sbr_obi_req_i.a.addr[1:0]};

endmodule

// File: rtl/user_bitstream_feeder.sv
// rtl/user_bitstream_feeder.sv - OBI manager copying LEN words from SRC to a fixed DST
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   sbr_obi_req_i/_rsp_o     configuration port (SRC, LEN, DST, CTRL/STATUS)
//   mgr_obi_req_o/_rsp_i     manager port towards memory and the accumulator
//   irq_o                    one-cycle pulse when a transfer ends (done or error)
module user_bitstream_feeder
    import user_bitstream_feeder_pkg::*;
#(
    parameter obi_cfg_t ObiCfg    = ObiDefaultConfig,
    parameter type      obi_req_t = obi_req_s,
    parameter type      obi_rsp_t = obi_rsp_s
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t sbr_obi_req_i,
    output obi_rsp_t sbr_obi_rsp_o,
    output obi_req_t mgr_obi_req_o,
    input  obi_rsp_t mgr_obi_rsp_i,
    output logic     irq_o
);

    feeder_state_e               state_q;
    logic [15:0]                 cnt_q;
    logic [ObiCfg.DataWidth-1:0] buf_q;
    logic                        done_q;
    logic                        err_q;
    logic                        irq_q;
    logic                        mreq_q;
    logic                        mwe_q;
    logic [31:0]                 maddr_q;

    logic [ObiCfg.AddrWidth-1:0] src;
    logic [ObiCfg.AddrWidth-1:0] dst;
    logic [15:0]                 len;
    logic                        start;
    logic                        busy;
    logic [15:0]                 cnt_inc;

    assign busy    = (state_q != StIdle);
    assign cnt_inc = cnt_q + 16'd1;

    user_bitstream_feeder_regs #(
        .ObiCfg    (ObiCfg),
        .obi_req_t (obi_req_t),
        .obi_rsp_t (obi_rsp_t)
    ) u_regs (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .sbr_obi_req_i (sbr_obi_req_i),
        .sbr_obi_rsp_o (sbr_obi_rsp_o),
        .busy_i        (busy),
        .done_i        (done_q),
        .err_i         (err_q),
        .cnt_i         (cnt_q),
        .src_o         (src),
        .len_o         (len),
        .dst_o         (dst),
        .start_o       (start)
    );

    // Request fields are loaded only when entering a REQ state and held until
    // the grant, so they are stable for the whole request phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
            maddr_q <= '0;
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                        done_q <= 1'b0;
                        if (len == 16'd0) begin
                            done_q <= 1'b1;
                            irq_q  <= 1'b1;
                        end else begin
                            state_q <= StRdReq;
                            mreq_q  <= 1'b1;
                            mwe_q   <= 1'b0;
                            maddr_q <= src;
                        end
                    end
                end
                StRdReq: begin
                    if (mgr_obi_rsp_i.gnt) begin
                        mreq_q  <= 1'b0;
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (mgr_obi_rsp_i.rvalid) begin
                        buf_q <= mgr_obi_rsp_i.r.rdata;
                        if (mgr_obi_rsp_i.r.err) begin
                            err_q   <= 1'b1;
                            irq_q   <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            state_q <= StWrReq;
                            mreq_q  <= 1'b1;
                            mwe_q   <= 1'b1;
                            maddr_q <= dst;
                        end
                    end
                end
                StWrReq: begin
                    if (mgr_obi_rsp_i.gnt) begin
                        mreq_q  <= 1'b0;
                        state_q <= StWrWait;
                    end
                end
                StWrWait: begin
                    if (mgr_obi_rsp_i.rvalid) begin
                        if (mgr_obi_rsp_i.r.err) begin
                            err_q   <= 1'b1;
                            irq_q   <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == len) begin
                                done_q  <= 1'b1;
                                irq_q   <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                state_q <= StRdReq;
                                mreq_q  <= 1'b1;
                                mwe_q   <= 1'b0;
                                // Word address arithmetic wraps modulo 2^32
                                maddr_q <= src + {14'd0, cnt_inc, 2'b00};
                            end
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    mreq_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mgr_obi_req_o         = '0;
        mgr_obi_req_o.req     = mreq_q;
        mgr_obi_req_o.a.addr  = maddr_q;
        mgr_obi_req_o.a.we    = mwe_q;
        mgr_obi_req_o.a.be    = 4'hF;
        mgr_obi_req_o.a.wdata = buf_q;
        mgr_obi_req_o.a.aid   = '0;
        mgr_obi_req_o.rready  = 1'b1;
    end

    assign irq_o = irq_q;

    logic unused_mgr;
    assign unused_mgr = ^mgr_obi_rsp_i.r.rid;

endmodule

// File: tb/tb_user_bitstream_feeder.sv
// tb/tb_user_bitstream_feeder.sv - randomized self-checking bench for user_bitstream_feeder
module tb_user_bitstream_feeder;
    import user_bitstream_feeder_pkg::*;

    localparam logic [31:0] AccPush = 32'h4000_0004;

    logic     clk = 1'b0;
    logic     rst_n;
    obi_req_s sbr_req;
    obi_rsp_s sbr_rsp;
    obi_req_s mgr_req;
    obi_rsp_s mgr_rsp;
    logic     irq;

    always #5 clk = ~clk;

    user_bitstream_feeder dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .sbr_obi_req_i (sbr_req),
        .sbr_obi_rsp_o (sbr_rsp),
        .mgr_obi_req_o (mgr_req),
        .mgr_obi_rsp_i (mgr_rsp),
        .irq_o         (irq)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xact_t;

    xact_t       exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int unsigned acc = 0;
    int          err_rd_idx = -1;
    int          rd_count = 0;
    int          gnt_lo = 0, gnt_hi = 0, rv_lo = 0, rv_hi = 0;
    bit          hold_wr = 0;
    int          req_cycles = 0;
    int          irq_cnt = 0;
    int          first_req_cyc = -1;

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // The expected bus trace of a transfer: read SRC+4i then write that word to DST,
    // cut short after the read that is told to fail.
    task automatic plan(input logic [31:0] src, input logic [15:0] len, input logic [31:0] dst,
                        input int err_idx, output logic [31:0] exp_st);
        xact_t x;
        exp_q.delete();
        rd_count   = 0;
        err_rd_idx = err_idx;
        for (int i = 0; i < int'(len); i++) begin
            x.we = 1'b0; x.addr = src + 32'(i) * 32'd4; x.wdata = 32'h0;
            exp_q.push_back(x);
            if (i == err_idx) break;
            x.we = 1'b1; x.wdata = memrd(src + 32'(i) * 32'd4); x.addr = dst;
            exp_q.push_back(x);
        end
        if (err_idx >= 0 && err_idx < int'(len)) exp_st = {16'(err_idx), 16'h0004};
        else                                     exp_st = {len, 16'h0002};
    endtask

    // ---------------- manager-side target ----------------
    int          t_phase = 0;   // 0 none, 2 waiting to grant, 1 response pending
    int          t_cnt = 0;
    obi_a_chan_t t_a;
    logic [31:0] t_rdata;
    logic        t_err;

    task automatic serve();
        xact_t e;
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL mgr_unexpected_req: got addr %h we %0d, expected no request", t_a.addr, t_a.we);
        end else begin
            e = exp_q.pop_front();
            chk("mgr_we", 32'(t_a.we), 32'(e.we));
            chk("mgr_addr", t_a.addr, e.addr);
            if (e.we) chk("mgr_wdata", t_a.wdata, e.wdata);
        end
        chk("mgr_be", 32'(t_a.be), 32'hF);
        t_err = 1'b0;
        t_rdata = 32'h0;
        if (t_a.we) begin
            if (t_a.addr == AccPush) acc += $countones(t_a.wdata);
            else                     mem[t_a.addr] = t_a.wdata;
        end else begin
            t_rdata = memrd(t_a.addr);
            t_err   = (rd_count == err_rd_idx);
            rd_count++;
        end
    endtask

    always @(negedge clk) begin
        mgr_rsp = '0;
        if (irq) irq_cnt++;
        if (!rst_n) begin
            t_phase = 0;
        end else begin
            if (mgr_req.req) begin
                req_cycles++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (t_phase == 1) begin
                chk("mgr_one_outstanding", 32'(mgr_req.req), 32'h0);
                if (t_cnt == 0) begin
                    mgr_rsp.rvalid  = 1'b1;
                    mgr_rsp.r.rdata = t_rdata;
                    mgr_rsp.r.err   = t_err;
                    t_phase = 0;
                end else begin
                    t_cnt--;
                end
            end else if (mgr_req.req) begin
                if (t_phase == 0) begin
                    t_a     = mgr_req.a;
                    t_cnt   = int'($urandom_range(gnt_hi, gnt_lo));
                    t_phase = 2;
                end else begin
                    chk("mgr_addr_stable", mgr_req.a.addr, t_a.addr);
                    chk("mgr_we_stable", 32'(mgr_req.a.we), 32'(t_a.we));
                    chk("mgr_wdata_stable", mgr_req.a.wdata, t_a.wdata);
                end
                if (t_cnt == 0 && !(hold_wr && t_a.we)) begin
                    mgr_rsp.gnt = 1'b1;
                    serve();
                    t_cnt   = int'($urandom_range(rv_hi, rv_lo));
                    t_phase = 1;
                end else if (t_cnt > 0) begin
                    t_cnt--;
                end
            end else if (t_phase == 2) begin
                n_vec++; n_err++;
                $display("FAIL mgr_req_dropped: got req 0 expected 1 before grant");
                t_phase = 0;
            end
        end
    end

    // ---------------- configuration port driver ----------------
    task automatic cfg_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err, output int req_cyc);
        logic [0:0] id;
        @(negedge clk);
        id = 1'($urandom);
        sbr_req.req     = 1'b1;
        sbr_req.a.we    = we;
        sbr_req.a.addr  = addr;
        sbr_req.a.wdata = wdata;
        sbr_req.a.be    = 4'hF;
        sbr_req.a.aid   = id;
        req_cyc = cyc;
        #1;
        chk("sbr_gnt", 32'(sbr_rsp.gnt), 32'h1);
        @(posedge clk);
        #1;
        sbr_req.req = 1'b0;
        chk("sbr_rvalid", 32'(sbr_rsp.rvalid), 32'h1);
        chk("sbr_rid", 32'(sbr_rsp.r.rid), 32'(id));
        rdata = sbr_rsp.r.rdata;
        err   = sbr_rsp.r.err;
    endtask

    task automatic cfg_wr(input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
        logic [31:0] rd; logic e; int rc;
        cfg_access(1'b1, addr, data, rd, e, rc);
        chk("sbr_write_err", 32'(e), 32'(exp_err));
    endtask

    task automatic cfg_rd(input logic [31:0] addr, output logic [31:0] data);
        logic e; int rc;
        cfg_access(1'b0, addr, 32'h0, data, e, rc);
        chk("sbr_read_err", 32'(e), 32'h0);
    endtask

    task automatic wait_irq(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (irq_cnt > 0) break;
        end
        if (i == bound) begin
            n_vec++; n_err++;
            $display("FAIL irq_timeout: got no irq expected one within %0d cycles", bound);
        end
    endtask

    task automatic run_xfer(input logic [31:0] src, input logic [15:0] len,
                            input logic [31:0] dst, input int err_idx);
        logic [31:0] exp_st, st;
        cfg_wr(32'h0, src, 1'b0);
        cfg_wr(32'h4, 32'(len), 1'b0);
        cfg_wr(32'h8, dst, 1'b0);
        plan(src, len, dst, err_idx, exp_st);
        irq_cnt = 0;
        cfg_wr(32'hC, 32'h1, 1'b0);
        wait_irq(4000);
        repeat (4) @(negedge clk);
        chk("irq_pulses", 32'(irq_cnt), 32'h1);
        chk("trace_complete", 32'(exp_q.size()), 32'h0);
        cfg_rd(32'hC, st);
        chk("status_model", st, exp_st);
    endtask

    task automatic check_regs_zero();
        logic [31:0] v;
        for (int r = 0; r < 4; r++) begin
            cfg_rd(32'(r * 4), v);
            chk("reg_is_zero", v, 32'h0);
        end
    endtask

    initial begin
        #500000;
        n_vec++; n_err++;
        $display("FAIL watchdog: got timeout expected test end");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        logic [31:0] v, st, src, dst;
        logic        e;
        int          rc, start_rc, done_cyc, base_req;
        logic [15:0] len;

        sbr_req = '0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("reset_mgr_req", 32'(mgr_req.req), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_sbr_rvalid", 32'(sbr_rsp.rvalid), 32'h0);
        check_regs_zero();

        // address alignment and LEN width
        cfg_wr(32'h0, 32'h1234_5677, 1'b0); cfg_rd(32'h0, v); chk("src_aligned", v, 32'h1234_5674);
        cfg_wr(32'h4, 32'hABCD_0007, 1'b0); cfg_rd(32'h4, v); chk("len_16bit", v, 32'h0000_0007);
        cfg_wr(32'h8, 32'h8765_4323, 1'b0); cfg_rd(32'h8, v); chk("dst_aligned", v, 32'h8765_4320);

        // popcount accumulation into the push register
        mem[32'h1000] = 32'hFFFF_FFFF; mem[32'h1004] = 32'h1; mem[32'h1008] = 32'h0;
        acc = 0;
        run_xfer(32'h1000, 16'd3, AccPush, -1);
        chk("acc_sum", acc, 32'd33);
        cfg_rd(32'hC, v);
        chk("status_done3", v, 32'h0003_0002);

        // zero-wait timing with LEN=4 and START immediately followed by a status read
        for (int i = 0; i < 4; i++) mem[32'h2000 + 32'(i) * 4] = $urandom;
        cfg_wr(32'h0, 32'h2000, 1'b0);
        cfg_wr(32'h4, 32'd4, 1'b0);
        cfg_wr(32'h8, 32'h8000_0100, 1'b0);
        plan(32'h2000, 16'd4, 32'h8000_0100, -1, st);
        irq_cnt = 0;
        first_req_cyc = -1;
        cfg_access(1'b1, 32'hC, 32'h1, v, e, start_rc);
        cfg_access(1'b0, 32'hC, 32'h0, v, e, rc);
        chk("status_after_start", v, 32'h0000_0001);
        done_cyc = -1;
        for (int i = 0; i < 60 && done_cyc < 0; i++) begin
            cfg_access(1'b0, 32'hC, 32'h0, v, e, rc);
            if (v[StatDoneBit]) done_cyc = rc;
        end
        chk("first_req_latency", 32'(first_req_cyc - start_rc), 32'd1);
        chk("done_latency", 32'(done_cyc - first_req_cyc), 32'd16);
        repeat (4) @(negedge clk);
        chk("irq_pulses_t", 32'(irq_cnt), 32'h1);
        chk("trace_complete_t", 32'(exp_q.size()), 32'h0);
        cfg_rd(32'hC, v);
        chk("status_done4", v, st);

        // random stalls and random contents, including an address wrap
        gnt_lo = 0; gnt_hi = 5; rv_lo = 0; rv_hi = 5;
        for (int t = 0; t < 5; t++) begin
            if (t == 4) begin
                src = 32'hFFFF_FFF8;
                len = 16'd4;
            end else begin
                src = 32'h0001_0000 + {$urandom_range(255, 0), 4'h0};
                len = 16'($urandom_range(10, 3));
            end
            dst = 32'h8000_0000 + {$urandom_range(255, 0), 2'b00};
            for (int i = 0; i < int'(len); i++) mem[src + 32'(i) * 4] = $urandom;
            run_xfer(src, len, dst, -1);
        end

        // read error on the second word
        for (int i = 0; i < 4; i++) mem[32'h3000 + 32'(i) * 4] = $urandom;
        run_xfer(32'h3000, 16'd4, 32'h8000_2000, 1);
        err_rd_idx = -1;
        cfg_rd(32'hC, v);
        chk("status_err", v, 32'h0001_0004);
        base_req = req_cycles;
        repeat (20) @(negedge clk);
        chk("no_req_after_err", 32'(req_cycles), 32'(base_req));

        // LEN = 0
        gnt_lo = 0; gnt_hi = 0; rv_lo = 0; rv_hi = 0;
        base_req = req_cycles;
        run_xfer(32'h3100, 16'd0, 32'h8000_3000, -1);
        chk("len0_no_req", 32'(req_cycles), 32'(base_req));
        cfg_rd(32'hC, v);
        chk("status_len0", v, 32'h0000_0002);

        // configuration writes while busy
        gnt_lo = 5; gnt_hi = 5;
        mem[32'h3200] = $urandom; mem[32'h3204] = $urandom;
        cfg_wr(32'h0, 32'h3200, 1'b0);
        cfg_wr(32'h4, 32'd2, 1'b0);
        cfg_wr(32'h8, 32'h8000_4000, 1'b0);
        plan(32'h3200, 16'd2, 32'h8000_4000, -1, st);
        irq_cnt = 0;
        cfg_wr(32'hC, 32'h1, 1'b0);
        cfg_wr(32'h0, 32'hDEAD_0000, 1'b1);
        cfg_rd(32'h0, v); chk("src_kept_busy", v, 32'h3200);
        cfg_wr(32'h4, 32'd9, 1'b1);
        cfg_rd(32'h4, v); chk("len_kept_busy", v, 32'd2);
        cfg_wr(32'hC, 32'h1, 1'b1);
        wait_irq(4000);
        repeat (4) @(negedge clk);
        chk("irq_pulses_busy", 32'(irq_cnt), 32'h1);
        chk("trace_complete_busy", 32'(exp_q.size()), 32'h0);
        cfg_rd(32'hC, v);
        chk("status_busy_xfer", v, 32'h0002_0002);

        // asynchronous reset while a write request is pending
        gnt_lo = 0; gnt_hi = 0;
        hold_wr = 1;
        mem[32'h5000] = $urandom; mem[32'h5004] = $urandom;
        cfg_wr(32'h0, 32'h5000, 1'b0);
        cfg_wr(32'h4, 32'd2, 1'b0);
        cfg_wr(32'h8, 32'h8000_5000, 1'b0);
        plan(32'h5000, 16'd2, 32'h8000_5000, -1, st);
        cfg_wr(32'hC, 32'h1, 1'b0);
        rc = 0;
        while (!(mgr_req.req && mgr_req.a.we) && rc < 100) begin
            @(negedge clk);
            rc++;
        end
        chk("wr_req_reached", 32'(mgr_req.req && mgr_req.a.we), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("reset_drops_req", 32'(mgr_req.req), 32'h0);
        exp_q.delete();
        hold_wr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_regs_zero();
        mem[32'h6000] = 32'h0F0F_0F0F;
        run_xfer(32'h6000, 16'd1, 32'h8000_6000, -1);
        cfg_rd(32'hC, v);
        chk("status_after_reset", v, 32'h0001_0002);
        chk("dst_written", memrd(32'h8000_6000), 32'h0F0F_0F0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
